// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter will use the same bit-period and frame-length constants.
package uart_pkg;

  localparam int CLK_PER_BIT_50M = 5208;
  localparam int CLK_PER_BIT_SIM = 12;
  localparam int FRAME_BITS      = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    B9,
    STOP,
    BREAK
  } rx_state_e;

  // Half a bit period, used to centre the first sample.
  function automatic int half_bit(input int clk_per_bit);
    return clk_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, plus one extra flop for
// falling-edge detection. Reusable for any async level input.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_s,
  input  logic rstn_s,
  input  logic din,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = dly & ~sync;

endmodule

// File: rtl/rs232_rx.sv
// UART receiver: start, 8 data bits LSB first, bit 9 (always 1), stop.
// Samples each bit at its centre and emits one-cycle valid / frame-error pulses.
module rs232_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_50M,
  parameter int CHECK_B9    = 1
) (
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic       iRX,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLK_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_s;
  logic fall;

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_s  (clk_s),
    .rstn_s (rstn_s),
    .din    (iRX),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  rx_state_e        state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift,   shift_n;
  logic             b9_ok,   b9_ok_n;
  logic [7:0]       data_q,  data_n;
  logic             vld_q,   vld_n;
  logic             err_q,   err_n;
  logic             tick;

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      b9_ok   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      b9_ok   <= b9_ok_n;
      data_q  <= data_n;
      vld_q   <= vld_n;
      err_q   <= err_n;
    end
  end

  // The counter runs down to zero; zero marks a bit-centre sample point.
  assign tick = (cnt == '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    b9_ok_n   = b9_ok;
    data_n    = data_q;
    vld_n     = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = CNT_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_n   = DATA;
            cnt_n     = CNT_FULL;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = CNT_FULL;
          if (bit_idx == 3'd7) begin
            state_n = B9;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      B9: begin
        if (tick) begin
          b9_ok_n = rx_s;
          cnt_n   = CNT_FULL;
          state_n = STOP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      STOP: begin
        // Leaving at mid-stop keeps half a bit of margin for a back-to-back start edge.
        if (tick) begin
          if (rx_s && (b9_ok || (CHECK_B9 == 0))) begin
            data_n  = shift;
            vld_n   = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign oDATA      = data_q;
  assign oVALID     = vld_q;
  assign oFRAME_ERR = err_q;
  assign oBUSY      = (state != IDLE);

endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- UART receiver matching the team's 9600 bps transmit frame format.
- Frame: start (0), 8 data bits LSB first, bit 9 (parity slot, always driven 1 by the transmitter), stop (1); 11 bit-times total.
- Oversamples the asynchronous serial line at the system clock and samples each bit at its centre.
- Delivers each byte with a one-cycle valid strobe to downstream logic, e.g. the LDPC decoder's host command/data loader.

Parameters:
- CLK_PER_BIT, 5208, system clocks per bit (50 MHz / 9600); simulation uses 12.
- CHECK_B9, 1, when 1 a sampled bit 9 of 0 is a frame error; when 0 bit 9 is ignored.

Ports:
- clk_s  in  1  system clock.
- rstn_s  in  1  asynchronous active-low reset.
- iRX  in  1  serial line, asynchronous to clk_s, idle high.
- oDATA  out  8  last correctly received byte; holds until the next good frame.
- oVALID  out  1  one-cycle pulse; oDATA is new on the same cycle.
- oFRAME_ERR  out  1  one-cycle pulse on a bad stop bit or bad bit 9.
- oBUSY  out  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset (async assert, sync release): oDATA=8'h00, oVALID=0, oFRAME_ERR=0, oBUSY=0, state=IDLE, counters=0, synchronizer flops=1.
- Input: 2-FF synchronizer on iRX gives rx_s. A third flop gives rx_d. Falling edge = rx_d & ~rx_s.
- Timing: let T = the cycle the falling edge is detected in IDLE, N = CLK_PER_BIT, H = N/2 (integer).
  - Start sampled at T+H.
  - Data bit k (0..7) sampled at T+H+(k+1)N.
  - Bit 9 sampled at T+H+9N.
  - Stop sampled at T+H+10N.
  - oVALID/oFRAME_ERR assert the cycle after the stop sample.
- Clock counter: width $clog2(N). It reloads on each sample and never wraps past N-1.
- States:
  - IDLE: oBUSY=0. Falling edge -> START.
  - START: at the sample point, rx_s=0 -> DATA (bit index 0); rx_s=1 -> IDLE (glitch rejected, no output pulse).
  - DATA: shift rx_s into a shift register, LSB first. After bit 7 -> B9.
  - B9: capture rx_s into b9_ok. -> STOP.
  - STOP:
    - rx_s=1 and (b9_ok or !CHECK_B9): oDATA<=shift, oVALID pulse -> IDLE. The return happens at mid-stop so the next start edge can be caught.
    - Otherwise: oFRAME_ERR pulse, oDATA unchanged -> BREAK.
  - BREAK: wait for rx_s=1 -> IDLE. A line held low (break) yields exactly one error and no further frames.
- Back-to-back frames with no idle gap are received without loss.
- oVALID and oFRAME_ERR are never high together and never high two cycles in a row.
- Reset mid-frame: immediate return to reset values. A partial frame produces no pulse. Reception resumes at the next falling edge after reset release.
- A falling edge while not in IDLE is ignored. Only the sample points matter.

Decomposition:
- Shared package uart_pkg:
  - CLK_PER_BIT_50M=5208, CLK_PER_BIT_SIM=12, FRAME_BITS=11.
  - rx state enum {IDLE, START, DATA, B9, STOP, BREAK}.
  - The transmitter migrates to the same constants later.
- One sub-module, uart_rx_sync: 2-FF synchronizer plus falling-edge detect, outputs rx_s and fall. It is reusable for other async inputs.

Test Plan (CLK_PER_BIT=12, CHECK_B9=1):
- Drive a frame carrying 8'hA5 (bit 9=1, stop=1), then idle -> exactly one oVALID, oDATA=8'hA5, pulse at T+6+120+1 relative to edge detection, oFRAME_ERR never high.
- Drive 8'h00 then 8'hFF back-to-back, zero idle bits -> two oVALID pulses 132 cycles apart, oDATA 8'h00 then 8'hFF.
- Drive a 3-cycle low glitch on idle iRX -> state returns to IDLE by cycle T+6, no pulses, oBUSY high for 6 cycles only.
- Drive frame 8'h3C with stop=0, hold iRX low 40 cycles, release, then send a valid 8'h5A:
  - exactly one oFRAME_ERR for the bad frame;
  - oDATA stays at its prior value through the error;
  - the next frame gives oVALID with oDATA=8'h5A.
- Drive frame 8'h81 with bit 9=0 -> oFRAME_ERR pulse. Repeat with CHECK_B9=0 -> oVALID, oDATA=8'h81.
- Assert rstn_s low for 2 cycles mid data bit 4, then send 8'hC3 -> no pulse from the aborted frame, outputs at reset values during reset, then oVALID with oDATA=8'hC3.
- Loopback with the team's UART transmitter at the same bit period: 256 sequential bytes 8'h00..8'hFF are received in order, with no errors.
